// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1/8N2 serial transmitter with a small byte FIFO in
// front and a fractional baud accumulator. Queued bytes go out back-to-back.
//
// state | meaning
// IDLE  | line high, accumulator held at 0, waiting for a queued byte
// START | start bit (line low)
// DATA  | eight data bits, LSB first
// STOP  | StopBits stop bits (line high)
module uart_tx_fifo #(
    parameter int ClkFrequency  = 7372800,
    parameter int Baud          = 38400,
    parameter int AccWidth      = 16,
    parameter int FifoDepthLog2 = 4,
    parameter int StopBits      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [FifoDepthLog2:0]   fifo_level,
    output logic                     TxD,
    output logic                     tx_busy,
    output logic                     frame_done
);

    localparam int Depth = 1 << FifoDepthLog2;
    localparam longint IncL = ((longint'(Baud) << (AccWidth - 4)) + (longint'(ClkFrequency) >> 5))
                              / (longint'(ClkFrequency) >> 4);
    localparam logic [AccWidth:0]        Inc      = (AccWidth + 1)'(IncL);
    localparam logic [FifoDepthLog2:0]   DepthLvl = (FifoDepthLog2 + 1)'(Depth);
    localparam logic [FifoDepthLog2:0]   LvlOne   = {{FifoDepthLog2{1'b0}}, 1'b1};
    localparam logic [FifoDepthLog2-1:0] PtrOne   = {{(FifoDepthLog2 - 1){1'b0}}, 1'b1};
    localparam logic [1:0]               LastStop = 2'(StopBits - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                   state;
    state_t                   nextState;
    logic [7:0]               mem [Depth];
    logic [FifoDepthLog2-1:0] rdPtr;
    logic [FifoDepthLog2-1:0] wrPtr;
    logic [7:0]               shiftReg;
    logic [2:0]               bitCnt;
    logic [1:0]               stopCnt;
    logic [AccWidth:0]        acc;
    logic                     tick;
    logic                     push;
    logic                     pop;
    logic                     frameEnd;

    // Reset holds off writers; otherwise a free slot is decided by the level register alone.
    assign wr_ready = !rst && (fifo_level < DepthLvl);
    assign push     = wr_valid && wr_ready;
    assign tick     = acc[AccWidth];
    assign tx_busy  = (state != IDLE);
    assign frameEnd = (state == STOP) && tick && (stopCnt == LastStop);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state decode; a pop loads the shifter on the same edge the FSM leaves IDLE/STOP.
    always_comb begin
        nextState = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    nextState = START;
                end
            end
            START: if (tick) nextState = DATA;
            DATA:  if (tick && bitCnt == 3'd7) nextState = STOP;
            STOP: begin
                if (frameEnd) begin
                    if (fifo_level != '0) begin
                        pop       = 1'b1;
                        nextState = START;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Baud accumulator: parked at zero whenever the FSM is or is about to be idle.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || nextState == IDLE) acc <= '0;
        else acc <= {1'b0, acc[AccWidth-1:0]} + Inc;
    end

    // FIFO storage; pointers wrap naturally at the depth.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= wr_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PtrOne;
            if (pop)  rdPtr <= rdPtr + PtrOne;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LvlOne;
                2'b01:   fifo_level <= fifo_level - LvlOne;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Shift register and bit/stop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg <= '0;
            bitCnt   <= '0;
            stopCnt  <= '0;
        end else begin
            if (pop) shiftReg <= mem[rdPtr];
            else if (state == DATA && tick) shiftReg <= {1'b0, shiftReg[7:1]};

            if (state == START) bitCnt <= '0;
            else if (state == DATA && tick) bitCnt <= bitCnt + 3'd1;

            if (state == DATA) stopCnt <= '0;
            else if (state == STOP && tick) stopCnt <= stopCnt + 2'd1;
        end
    end

    // Registered line driver and end-of-frame pulse, one clock behind the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            TxD        <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            case (state)
                START:   TxD <= 1'b0;
                DATA:    TxD <= shiftReg[0];
                default: TxD <= 1'b1;
            endcase
            frame_done <= frameEnd;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural line receiver decodes TxD at mid-bit
// and compares each byte against a queue of accepted bytes.
module tb_uart_tx_fifo;

    localparam int  IncRef = ((38400 << 12) + (7372800 >> 5)) / (7372800 >> 4);
    localparam real BitP   = 65536.0 / real'(IncRef);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [4:0] fifo_level;
    logic       TxD;
    logic       tx_busy;
    logic       frame_done;

    logic [7:0] wrData2 = 8'h00;
    logic       wrValid2 = 1'b0;
    logic       wrReady2;
    logic [4:0] level2;
    logic       txd2;
    logic       busy2;
    logic       done2;

    int nCompared = 0;
    int nMismatch = 0;
    int doneCnt = 0;
    bit monEnable = 1'b1;
    logic [7:0] expQ[$];

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .fifo_level(fifo_level), .TxD(TxD),
        .tx_busy(tx_busy), .frame_done(frame_done)
    );

    uart_tx_fifo #(.Baud(115200), .StopBits(2)) dut2 (
        .clk(clk), .rst(rst), .wr_data(wrData2), .wr_valid(wrValid2),
        .wr_ready(wrReady2), .fifo_level(level2), .TxD(txd2),
        .tx_busy(busy2), .frame_done(done2)
    );

    task automatic checkVal(input string tag, input longint got, input longint exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Collapse a value inside [lo,hi] onto nominal so the check reports the raw value only when out of range.
    function automatic longint inWindow(input longint v, input longint lo, input longint hi, input longint nominal);
        return (v >= lo && v <= hi) ? nominal : v;
    endfunction

    task automatic pushByte(input logic [7:0] b, input int budget);
        int n;
        wr_data  = b;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkVal("push_timeout", n, 0);
        else expQ.push_back(b);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (300) @(negedge clk);
        checkVal(tag, expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        if (frame_done) doneCnt++;
    end

    // Line receiver: start detected on a low line, then sample at bit centres.
    initial begin : rxMonitor
        int t;
        logic [9:0] bits;
        forever begin
            @(negedge clk);
            if (!rst && TxD === 1'b0) begin
                t = 0;
                bits = '0;
                for (int i = 0; i <= 9; i++) begin
                    while (t < int'((real'(i) + 0.5) * BitP)) begin
                        @(negedge clk);
                        t++;
                    end
                    bits[i] = TxD;
                end
                if (monEnable) begin
                    checkVal("rx_start_bit", bits[0], 0);
                    checkVal("rx_stop_bit", bits[9], 1);
                    if (expQ.size() == 0) checkVal("rx_unexpected_byte", bits[8:1], -1);
                    else checkVal("rx_byte", bits[8:1], expQ.pop_front());
                end
            end
        end
    end

    initial begin : mainSeq
        int n, dur, lows, busyLow, seen, prevDone, accepted, d0, gap, doneAt, stopLows;
        logic [7:0] nextByte;
        logic [10:0] frame2;
        bit take;

        // Reset dominates a pending write.
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            checkVal("rst_txd", TxD, 1);
            checkVal("rst_busy", tx_busy, 0);
            checkVal("rst_level", fifo_level, 0);
            checkVal("rst_ready", wr_ready, 0);
        end
        rst = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        checkVal("ready_after_rst", wr_ready, 1);
        checkVal("level_after_rst", fifo_level, 0);
        repeat (5) @(negedge clk);
        checkVal("nothing_queued", tx_busy, 0);

        // Single byte 0xA5.
        pushByte(8'hA5, 10);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkVal("a5_busy_rise", tx_busy, 1);
        dur = 0;
        while (!frame_done && dur < 3000) begin
            @(negedge clk);
            dur++;
        end
        checkVal("a5_frame_len", inWindow(dur, 1921, 1923, 1922), 1922);
        checkVal("a5_idle_at_done", tx_busy, 0);
        @(negedge clk);
        checkVal("a5_done_one_cycle", frame_done, 0);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!TxD) lows++;
        end
        checkVal("a5_line_idle_after", lows, 0);
        waitDrain("a5_drain", 500);

        // Back-to-back frames.
        pushByte(8'h00, 10);
        pushByte(8'hFF, 10);
        pushByte(8'h55, 10);
        checkVal("b2b_level_start", fifo_level, 2);
        n = 0; seen = 0; busyLow = 0; prevDone = 0;
        while (seen < 3 && n < 7000) begin
            @(negedge clk);
            n++;
            if (!tx_busy && !frame_done) busyLow++;
            if (frame_done) begin
                checkVal($sformatf("b2b_level_done%0d", seen), fifo_level, (seen == 0) ? 1 : 0);
                if (seen > 0) checkVal($sformatf("b2b_spacing%0d", seen), inWindow(n - prevDone, 1921, 1923, 1922), 1922);
                if (seen < 2) checkVal($sformatf("b2b_busy_done%0d", seen), tx_busy, 1);
                prevDone = n;
                seen++;
            end
        end
        checkVal("b2b_frames", seen, 3);
        checkVal("b2b_no_gap", busyLow, 0);
        waitDrain("b2b_drain", 1000);

        // Fill the FIFO: 18 cycles of continuous writes.
        accepted = 0;
        nextByte = 8'd0;
        wr_valid = 1'b1;
        for (int c = 0; c < 18; c++) begin
            wr_data = nextByte;
            take = wr_ready;
            if (take) expQ.push_back(nextByte);
            @(negedge clk);
            if (take) begin
                accepted++;
                nextByte = nextByte + 8'd1;
            end
        end
        checkVal("full_accepted", accepted, 17);
        checkVal("full_ready_low", wr_ready, 0);
        checkVal("full_level", fifo_level, 16);
        checkVal("full_held_byte", nextByte, 17);
        pushByte(nextByte, 5000);
        waitDrain("full_drain", 40000);

        // Reset in the middle of data bit 3 with four bytes queued.
        pushByte(8'h3C, 10);
        pushByte(8'h11, 10);
        pushByte(8'h22, 10);
        pushByte(8'h33, 10);
        pushByte(8'h44, 10);
        checkVal("mid_level", fifo_level, 4);
        n = 0;
        while (TxD && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkVal("mid_start_seen", TxD, 0);
        repeat (int'(4.5 * BitP)) @(negedge clk);
        monEnable = 1'b0;
        d0 = doneCnt;
        rst = 1'b1;
        @(negedge clk);
        checkVal("mid_txd", TxD, 1);
        checkVal("mid_level_clr", fifo_level, 0);
        checkVal("mid_busy", tx_busy, 0);
        rst = 1'b0;
        lows = 0; busyLow = 0;
        repeat (2500) begin
            @(negedge clk);
            if (!TxD) lows++;
            if (tx_busy) busyLow++;
        end
        checkVal("mid_line_quiet", lows, 0);
        checkVal("mid_no_frames", busyLow, 0);
        checkVal("mid_no_done", doneCnt, d0);
        expQ.delete();
        monEnable = 1'b1;

        // Randomized bytes with random gaps.
        for (int k = 0; k < 12; k++) begin
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 400) : 0;
            repeat (gap) @(negedge clk);
            pushByte(8'($urandom), 5000);
        end
        waitDrain("rand_drain", 30000);

        // 8N2 at 115200: exactly 64 clocks per bit.
        frame2 = {2'b11, 8'h81, 1'b0};
        wrData2  = 8'h81;
        wrValid2 = 1'b1;
        checkVal("s2_ready", wrReady2, 1);
        @(negedge clk);
        wrValid2 = 1'b0;
        n = 0;
        while (txd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkVal("s2_start_seen", txd2, 0);
        doneAt = -1;
        stopLows = 0;
        for (int t = 0; t <= 760; t++) begin
            if (t > 0) @(negedge clk);
            if (t % 64 == 32 && t / 64 <= 10) checkVal($sformatf("s2_bit%0d", t / 64), txd2, frame2[t / 64]);
            if (t >= 580 && t <= 700 && !txd2) stopLows++;
            if (done2 && doneAt < 0) doneAt = t;
        end
        checkVal("s2_stop_high", stopLows, 0);
        checkVal("s2_done_time", inWindow(doneAt, 700, 708, 704), 704);
        checkVal("s2_idle", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
